// File: rtl/wfc_pkg.sv
// Shared types and constants for the window fetch controller: FSM encoding,
// default frame geometry, neighbour index constants and the frame-edge test.
package wfc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StBorder,
    StDrain,
    StPresent,
    StNext,
    StDone
  } wfc_state_e;

  localparam int unsigned DEF_IMG_W  = 160;
  localparam int unsigned DEF_IMG_H  = 120;
  localparam int unsigned X_W        = 8;
  localparam int unsigned Y_W        = 7;
  localparam int unsigned SEL_W      = 4;
  localparam logic [3:0]  SEL_CENTRE = 4'd4;
  localparam logic [3:0]  SEL_LAST   = 4'd8;

  // A centre pixel on the frame edge has neighbours outside the frame.
  function automatic logic on_edge(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                   input int unsigned w, input int unsigned h);
    return (x == '0) || (x == X_W'(w - 1)) || (y == '0) || (y == Y_W'(h - 1));
  endfunction

endpackage

// File: rtl/window_fetch_ctrl_if.sv
// Control, frame RAM read and window output signals of the window fetch controller.
// master is the controller side, slave is the RAM / downstream / sequencer side.
interface window_fetch_ctrl_if
  import wfc_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) ();

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [X_W-1:0]       x_o;
  logic [Y_W-1:0]       y_o;
  logic [SEL_W-1:0]     sel_o;
  logic                 rd_en;
  logic [PIX_W-1:0]     rd_data;
  logic                 win_valid;
  logic                 win_ready;
  logic [9*PIX_W-1:0]   win_data;
  logic [X_W-1:0]       win_x;
  logic [Y_W-1:0]       win_y;
  logic                 win_border;

  modport master (
    input  start, rd_data, win_ready,
    output busy, done, x_o, y_o, sel_o, rd_en, win_valid, win_data, win_x, win_y, win_border
  );

  modport slave (
    output start, rd_data, win_ready,
    input  busy, done, x_o, y_o, sel_o, rd_en, win_valid, win_data, win_x, win_y, win_border
  );

endinterface

// File: rtl/win_capture.sv
// Delays each read's neighbour index by the RAM latency and writes the returned
// pixel into the matching slot of a 9-entry window register file.
module win_capture #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en_i,
  input  logic [3:0]         sel_i,
  input  logic [PIX_W-1:0]   rd_data_i,
  input  logic               clear_i,
  output logic [9*PIX_W-1:0] win_data_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [3:0]        tag_q [RD_LAT];
  logic [PIX_W-1:0]  slot_q [9];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_en_i;
      tag_q[0] <= sel_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Slots are only overwritten, never cleared between interior windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) slot_q[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < 9; k++) slot_q[k] <= '0;
    end else if (vld_q[RD_LAT-1]) begin
      for (int k = 0; k < 9; k++) begin
        if (tag_q[RD_LAT-1] == 4'(k)) slot_q[k] <= rd_data_i;
      end
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign win_data_o[k*PIX_W +: PIX_W] = slot_q[k];
  end

endmodule

// File: rtl/window_fetch_ctrl.sv
// Raster-scans the frame, issues nine neighbourhood reads per interior pixel and
// presents each captured 3x3 window over a valid/ready handshake.
module window_fetch_ctrl
  import wfc_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  window_fetch_ctrl_if.master bus
);

  wfc_state_e       st_q;
  logic             busy_q;
  logic             done_q;
  logic             rd_en_q;
  logic             win_valid_q;
  logic             win_border_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [SEL_W-1:0] sel_q;
  logic [1:0]       dcnt_q;

  logic             last_px;
  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;
  logic             nx_edge;
  logic             clear;

  always_comb begin
    last_px = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));
    if (x_q == X_W'(IMG_W - 1)) begin
      nx = '0;
      ny = y_q + Y_W'(1);
    end else begin
      nx = x_q + X_W'(1);
      ny = y_q;
    end
    nx_edge = on_edge(nx, ny, IMG_W, IMG_H);
  end

  assign clear = (st_q == StBorder);

  // The NEXT step (advance and edge test) is taken on the accepting PRESENT edge,
  // so the following fetch starts the cycle after the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      win_valid_q  <= 1'b0;
      win_border_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      sel_q        <= '0;
      dcnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        StIdle: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            x_q    <= '0;
            y_q    <= '0;
            st_q   <= StBorder;
          end
        end
        StFetch: begin
          if (sel_q == SEL_LAST) begin
            rd_en_q <= 1'b0;
            dcnt_q  <= 2'(RD_LAT - 1);
            st_q    <= StDrain;
          end else begin
            sel_q <= sel_q + SEL_W'(1);
          end
        end
        StDrain: begin
          if (dcnt_q == '0) begin
            win_valid_q <= 1'b1;
            st_q        <= StPresent;
          end else begin
            dcnt_q <= dcnt_q - 2'd1;
          end
        end
        StBorder: begin
          win_border_q <= 1'b1;
          win_valid_q  <= 1'b1;
          st_q         <= StPresent;
        end
        StPresent: begin
          if (bus.win_ready) begin
            win_valid_q <= 1'b0;
            if (last_px) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              st_q   <= StDone;
            end else begin
              x_q <= nx;
              y_q <= ny;
              if (nx_edge) begin
                st_q <= StBorder;
              end else begin
                win_border_q <= 1'b0;
                rd_en_q      <= 1'b1;
                sel_q        <= '0;
                st_q         <= StFetch;
              end
            end
          end
        end
        StDone:  st_q <= StIdle;
        default: st_q <= StIdle;
      endcase
    end
  end

  win_capture #(
    .PIX_W  (PIX_W),
    .RD_LAT (RD_LAT)
  ) u_capture (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (rd_en_q),
    .sel_i      (sel_q),
    .rd_data_i  (bus.rd_data),
    .clear_i    (clear),
    .win_data_o (bus.win_data)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.sel_o      = sel_q;
  assign bus.x_o        = x_q;
  assign bus.y_o        = y_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_border = win_border_q;
  assign bus.win_x      = x_q;
  assign bus.win_y      = y_q;

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Randomized-handshake bench for window_fetch_ctrl against a raster-order window model.
// Frame height is reduced so full scans stay short; expected counts follow the geometry.
module tb_window_fetch_ctrl;

  localparam int unsigned IMG_W  = 160;
  localparam int unsigned IMG_H  = 8;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned RD_LAT = 1;
  localparam int          TOTAL  = IMG_W * IMG_H;
  localparam int          BUDGET = 40000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_fetch_ctrl_if #(.PIX_W(PIX_W)) bus ();

  window_fetch_ctrl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_W  (PIX_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Frame RAM: byte at linear address of the addressed neighbour, RD_LAT cycles late.
  logic [PIX_W-1:0] ram_pipe [RD_LAT];
  assign bus.rd_data = ram_pipe[RD_LAT-1];

  function automatic logic [PIX_W-1:0] ram_byte(input int x, input int y, input int sel);
    int a;
    a = (y + sel / 3 - 1) * IMG_W + (x + sel % 3 - 1);
    return a[PIX_W-1:0];
  endfunction

  always @(posedge clk) begin
    ram_pipe[0] <= bus.rd_en ? ram_byte(int'(bus.x_o), int'(bus.y_o), int'(bus.sel_o))
                             : PIX_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_border(input int x, input int y);
    return (x == 0) || (x == IMG_W - 1) || (y == 0) || (y == IMG_H - 1);
  endfunction

  function automatic logic [9*PIX_W-1:0] exp_win(input int x, input int y);
    logic [9*PIX_W-1:0] w;
    w = '0;
    if (!is_border(x, y)) begin
      for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = ram_byte(x, y, k);
    end
    return w;
  endfunction

  // Scoreboard state
  int   cyc, win_idx, sel_cnt, first_rd, transfers, interiors, dones, ready_mode, stall55;
  int   exp_rd_next;
  logic prev_valid, prev_busy, acc_prev, stall_prev;
  logic [9*PIX_W-1:0] snap_data;
  logic [7:0] snap_x;
  logic [6:0] snap_y;
  logic       snap_b;

  task automatic sb_clear();
    cyc = 0; win_idx = 0; sel_cnt = 0; first_rd = 0; transfers = 0; interiors = 0;
    dones = 0; stall55 = 0; exp_rd_next = 0;
    prev_valid = 0; prev_busy = 0; acc_prev = 0; stall_prev = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},   bus.busy, 0);
    check({tag, "_done"},   bus.done, 0);
    check({tag, "_rd_en"},  bus.rd_en, 0);
    check({tag, "_valid"},  bus.win_valid, 0);
    check({tag, "_border"}, bus.win_border, 0);
    check({tag, "_xyo"},    {bus.x_o, bus.y_o, bus.sel_o}, 0);
    check({tag, "_winxy"},  {bus.win_x, bus.win_y}, 0);
    check({tag, "_data"},   bus.win_data, 0);
  endtask

  // One clock: sample at negedge, check, then choose win_ready for the coming edge.
  task automatic cycle_step();
    logic r;
    int ex, ey;
    logic [71:0] w11;
    @(negedge clk);
    cyc++;
    ex = win_idx % IMG_W;
    ey = win_idx / IMG_W;
    if (acc_prev) begin
      check("valid_drop", bus.win_valid, 0);
      check("next_fetch", bus.rd_en, exp_rd_next[0]);
    end
    if (stall_prev) begin
      check("stall_valid", bus.win_valid, 1);
      check("stall_data", bus.win_data, snap_data);
      check("stall_xyb", {bus.win_x, bus.win_y, bus.win_border}, {snap_x, snap_y, snap_b});
    end
    if (bus.win_valid) check("rd_while_valid", bus.rd_en, 0);
    if (bus.rd_en) begin
      if (sel_cnt == 0) first_rd = cyc;
      check("rd_pixel", {bus.x_o, bus.y_o, bus.sel_o}, {ex[7:0], ey[6:0], sel_cnt[3:0]});
      check("rd_interior", is_border(ex, ey), 0);
      sel_cnt++;
    end
    if (bus.win_valid && !prev_valid) begin
      check("fetch_len", sel_cnt, is_border(ex, ey) ? 0 : 9);
      if (!is_border(ex, ey)) check("latency", cyc - first_rd, 9 + RD_LAT);
      sel_cnt = 0;
    end
    if (bus.done) begin
      dones++;
      check("done_busy", bus.busy, 0);
      check("busy_before_done", prev_busy, 1);
      check("done_after_last", win_idx, TOTAL);
    end

    if (ready_mode == 0) begin
      r = 1'b1;
    end else if (win_idx == 5 * IMG_W + 5 && stall55 < 20) begin
      r = 1'b0;
      if (bus.win_valid) stall55++;
    end else begin
      r = ($urandom_range(0, 3) != 0);
    end
    bus.win_ready = r;

    acc_prev = 0;
    stall_prev = 0;
    if (bus.win_valid && r) begin
      check("win_xy", {bus.win_x, bus.win_y}, {ex[7:0], ey[6:0]});
      check("win_border", bus.win_border, is_border(ex, ey));
      check("win_data", bus.win_data, exp_win(ex, ey));
      if (ex == 1 && ey == 1) begin
        w11 = 72'h42_41_40_A2_A1_A0_02_01_00;
        check("win_1_1", bus.win_data, w11);
      end
      transfers++;
      if (!is_border(ex, ey)) interiors++;
      win_idx++;
      acc_prev = 1;
      exp_rd_next = (win_idx < TOTAL) ? int'(!is_border(win_idx % IMG_W, win_idx / IMG_W)) : 0;
    end else if (bus.win_valid) begin
      stall_prev = 1;
      snap_data = bus.win_data;
      snap_x = bus.win_x;
      snap_y = bus.win_y;
      snap_b = bus.win_border;
    end
    prev_valid = bus.win_valid;
    prev_busy = bus.busy;
  endtask

  task automatic start_frame(input int mode);
    sb_clear();
    ready_mode = mode;
    bus.start = 1'b1;
    cycle_step();
    bus.start = 1'b0;
    check("busy_on_start", bus.busy, 1);
  endtask

  task automatic run_to_done(input bit spurious_starts);
    for (int c = 0; c < BUDGET; c++) begin
      cycle_step();
      if (dones > 0) break;
      bus.start = spurious_starts && bus.busy && ($urandom_range(0, 299) == 0);
    end
    bus.start = 1'b0;
    check("frame_done", dones, 1);
    check("transfers", transfers, TOTAL);
    check("interiors", interiors, (IMG_W - 2) * (IMG_H - 2));
  endtask

  initial begin
    bit hit;
    bus.start = 1'b0;
    bus.win_ready = 1'b0;
    sb_clear();
    ready_mode = 0;
    rst = 1'b1;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Frame 1: random backpressure, long stall at (5,5), stray starts, start in DONE.
    start_frame(1);
    run_to_done(1'b1);
    bus.start = 1'b1;
    cycle_step();
    bus.start = 1'b0;
    check("start_in_done", bus.busy, 0);
    check("stall55_seen", stall55, 20);
    for (int i = 0; i < 3; i++) begin
      cycle_step();
      check("idle_hold", {bus.busy, bus.win_valid, bus.rd_en}, 0);
    end

    // Frame 2: asynchronous reset during the fetch of window (80,4).
    start_frame(0);
    hit = 0;
    for (int c = 0; c < BUDGET; c++) begin
      cycle_step();
      if (bus.rd_en && bus.x_o == 8'd80 && bus.y_o == 7'd4 && bus.sel_o == 4'd3) begin
        hit = 1;
        break;
      end
    end
    check("abort_reached", hit, 1);
    rst = 1'b1;
    #1 check_reset("mid");
    #1 rst = 1'b0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      @(negedge clk);
      check("no_stale_write", bus.win_data, 0);
      check("post_reset_idle", {bus.busy, bus.win_valid, bus.rd_en}, 0);
    end

    // Frame 3: fresh scan from (0,0), win_ready tied high.
    start_frame(0);
    run_to_done(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
